neokeon_round_engine: RTL and testbench

- Iterative Noekeon-128 encryption core in direct-key mode.
- Sits directly downstream of the 32-bit rotate-left-by-8 function: it instantiates that function, together with a rotate-right-by-8 counterpart, inside its Theta step.
- Consumes one 128-bit plaintext and one 128-bit key, runs 16 rounds at one round per clock, then applies the output transform and presents the 128-bit ciphertext.

---
 rtl/neokeon_round_engine.sv | 151 +++++++++++++++
 tb/tb_neokeon_round_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/neokeon_round_engine.sv
// Iterative Noekeon-128 encryption core, direct-key mode.
// One round per clock, 16 rounds plus an output transform, so a block takes 18 cycles from start to start.

// 32-bit rotate left by 8.
module neokeonRotl8 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[23:0], x[31:24]};
endmodule

// 32-bit rotate right by 8.
module neokeonRotr8 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[7:0], x[31:8]};
endmodule

// Theta: linear mixing layer with the working key folded in between the two halves.
module neokeonTheta (
  input  logic [127:0] a,
  input  logic [127:0] k,
  output logic [127:0] y
);
  logic [31:0] t0, t0l, t0r, t0x;
  logic [31:0] t1, t1l, t1r, t1x;
  logic [31:0] c0, c1, c2, c3;

  assign t0 = a[127:96] ^ a[63:32];
  neokeonRotl8 uRotlA (.x(t0), .y(t0l));
  neokeonRotr8 uRotrA (.x(t0), .y(t0r));
  assign t0x = t0 ^ t0l ^ t0r;

  assign c0 = a[127:96] ^ k[127:96];
  assign c1 = a[95:64] ^ t0x ^ k[95:64];
  assign c2 = a[63:32] ^ k[63:32];
  assign c3 = a[31:0] ^ t0x ^ k[31:0];

  assign t1 = c1 ^ c3;
  neokeonRotl8 uRotlB (.x(t1), .y(t1l));
  neokeonRotr8 uRotrB (.x(t1), .y(t1r));
  assign t1x = t1 ^ t1l ^ t1r;

  assign y = {c0 ^ t1x, c1, c2 ^ t1x, c3};
endmodule

module neokeon_round_engine #(
  parameter int         NUM_ROUNDS = 16,
  parameter logic [7:0] RC_INIT    = 8'h80
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inStart,
  input  logic [127:0] inDataBlock,
  input  logic [127:0] inKey,
  output logic [127:0] outDataBlock,
  output logic         outValid,
  output logic         outBusy
);
  localparam int CW = $clog2(NUM_ROUNDS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINAL} fsm_t;

  fsm_t          curState, nextState;
  logic [127:0]  stateReg, keyReg;
  logic [CW-1:0] roundCnt;
  logic [7:0]    rc, rcNext;
  logic [127:0]  thetaIn, thetaOut, roundOut;
  logic [31:0]   g0, g1, g2, g3, gTmp;
  logic          lastRound;

  // Round constant injection is shared by RUN and FINAL, so one Theta serves both.
  assign thetaIn   = {stateReg[127:96] ^ {24'b0, rc}, stateReg[95:0]};
  assign rcNext    = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  assign lastRound = (roundCnt == CW'(NUM_ROUNDS - 1));

  neokeonTheta uTheta (.a(thetaIn), .k(keyReg), .y(thetaOut));

  // Pi1, Gamma, Pi2 on the Theta output to form the next round state.
  always_comb begin
    g0 = thetaOut[127:96];
    g1 = {thetaOut[94:64], thetaOut[95]};
    g2 = {thetaOut[58:32], thetaOut[63:59]};
    g3 = {thetaOut[29:0], thetaOut[31:30]};
    g1 = g1 ^ (~g3 & ~g2);
    g0 = g0 ^ (g2 & g1);
    gTmp = g0;
    g0 = g3;
    g3 = gTmp;
    g2 = g2 ^ g0 ^ g1 ^ g3;
    g1 = g1 ^ (~g3 & ~g2);
    g0 = g0 ^ (g2 & g1);
    roundOut = {g0, {g1[0], g1[31:1]}, {g2[4:0], g2[31:5]}, {g3[1:0], g3[31:2]}};
  end

  // FSM state register.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) curState <= IDLE;
    else       curState <= nextState;
  end

  // Next-state logic: start only from IDLE, FINAL always returns to IDLE.
  always_comb begin
    nextState = curState;
    case (curState)
      IDLE:    if (inStart) nextState = RUN;
      RUN:     if (lastRound) nextState = FINAL;
      FINAL:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath: latch on start, one round per RUN cycle, output transform in FINAL.
  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      stateReg     <= '0;
      keyReg       <= '0;
      roundCnt     <= '0;
      rc           <= RC_INIT;
      outDataBlock <= '0;
      outValid     <= 1'b0;
      outBusy      <= 1'b0;
    end else begin
      outValid <= 1'b0;
      case (curState)
        IDLE: begin
          if (inStart) begin
            stateReg <= inDataBlock;
            keyReg   <= inKey;
            roundCnt <= '0;
            rc       <= RC_INIT;
            outBusy  <= 1'b1;
          end
        end
        RUN: begin
          stateReg <= roundOut;
          roundCnt <= roundCnt + CW'(1);
          rc       <= rcNext;
        end
        FINAL: begin
          stateReg     <= thetaOut;
          outDataBlock <= thetaOut;
          outValid     <= 1'b1;
          outBusy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neokeon_round_engine.sv
// Randomized self-checking bench for neokeon_round_engine against a word-level Noekeon model.
module tb_neokeon_round_engine;
  typedef logic [0:3][31:0] blk_t;

  localparam logic [127:0] KAT = 128'hb1656851_699e29fa_24b70148_503d2dfc;

  logic         inClk = 1'b0;
  logic         inRst;
  logic         inStart;
  logic [127:0] inDataBlock, inKey, outDataBlock;
  logic         outValid, outBusy;

  int total = 0;
  int bad   = 0;

  logic [7:0] rcTbl [0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                               8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

  always #5 inClk = ~inClk;

  neokeon_round_engine dut (
    .inClk(inClk), .inRst(inRst), .inStart(inStart),
    .inDataBlock(inDataBlock), .inKey(inKey),
    .outDataBlock(outDataBlock), .outValid(outValid), .outBusy(outBusy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] r);
    int v;
    v = int'(r) * 2;
    if (v >= 256) v = v ^ 'h11B;
    return v[7:0];
  endfunction

  function automatic blk_t mTheta(input blk_t a, input blk_t k);
    logic [31:0] t;
    t = a[0] ^ a[2];
    t = t ^ rotl(t, 8) ^ rotl(t, 24);
    a[1] ^= t; a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[i];
    t = a[1] ^ a[3];
    t = t ^ rotl(t, 8) ^ rotl(t, 24);
    a[0] ^= t; a[2] ^= t;
    return a;
  endfunction

  function automatic blk_t mGamma(input blk_t a);
    logic [31:0] s;
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    s = a[0]; a[0] = a[3]; a[3] = s;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    return a;
  endfunction

  function automatic blk_t mRound(input blk_t a, input blk_t k, input logic [7:0] r);
    a[0] ^= {24'b0, r};
    a = mTheta(a, k);
    a[1] = rotl(a[1], 1); a[2] = rotl(a[2], 5); a[3] = rotl(a[3], 2);
    a = mGamma(a);
    a[1] = rotl(a[1], 31); a[2] = rotl(a[2], 27); a[3] = rotl(a[3], 30);
    return a;
  endfunction

  function automatic logic [127:0] refState(input logic [127:0] pt, input logic [127:0] key, input int n);
    blk_t a = pt;
    blk_t k = key;
    logic [7:0] r = 8'h80;
    for (int i = 0; i < n; i++) begin
      a = mRound(a, k, r);
      r = xt(r);
    end
    return a;
  endfunction

  function automatic logic [127:0] refCt(input logic [127:0] pt, input logic [127:0] key);
    blk_t a = pt;
    blk_t k = key;
    logic [7:0] r = 8'h80;
    for (int i = 0; i < 16; i++) begin
      a = mRound(a, k, r);
      r = xt(r);
    end
    a[0] ^= {24'b0, r};
    return mTheta(a, k);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete block with per-cycle rc/state probes; optional stray start at RUN cycle lockAt.
  task automatic runOne(input logic [127:0] pt, input logic [127:0] key, input int lockAt);
    int vCnt = 0;
    int bCnt = 0;
    @(negedge inClk);
    inStart = 1'b1; inDataBlock = pt; inKey = key;
    for (int c = 0; c <= 18; c++) begin
      @(negedge inClk);
      if (c <= 15) chk("rc", 128'(dut.rc), 128'(rcTbl[c]));
      if (c <= 16) chk("state", dut.stateReg, refState(pt, key, c));
      if (c == 16) chk("rcFinal", 128'(dut.rc), 128'(rcTbl[16]));
      if (outBusy)  bCnt++;
      if (outValid) vCnt++;
      if (c == 17) begin
        chk("validPulse", 128'(outValid), 128'(1));
        chk("ct", outDataBlock, refCt(pt, key));
      end
      inStart     = (c == lockAt);
      inDataBlock = rnd128();
      inKey       = rnd128();
    end
    inStart = 1'b0;
    chk("busyCycles", 128'(bCnt), 128'(17));
    chk("validCount", 128'(vCnt), 128'(1));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    logic [127:0] q[$];
    int cyc, last, nres, vCnt, bCnt;
    bit changePending;

    inRst = 1'b1; inStart = 1'b0; inDataBlock = '0; inKey = '0;
    repeat (3) @(negedge inClk);
    chk("rstOut", outDataBlock, 128'(0));
    chk("rstValid", 128'(outValid), 128'(0));
    chk("rstBusy", 128'(outBusy), 128'(0));
    chk("rstRc", 128'(dut.rc), 128'(8'h80));
    inRst = 1'b0;

    // All-zero known answer, checked against the published vector as well as the model.
    runOne('0, '0, -1);
    chk("katConst", outDataBlock, KAT);
    held = outDataBlock;
    repeat (4) @(negedge inClk);
    chk("holdOut", outDataBlock, held);
    chk("idleValid", 128'(outValid), 128'(0));

    // Asynchronous reset between edges during a block.
    @(negedge inClk);
    inStart = 1'b1; inDataBlock = rnd128(); inKey = rnd128();
    @(negedge inClk);
    inStart = 1'b0;
    repeat (3) @(negedge inClk);
    #2 inRst = 1'b1;
    #1;
    chk("asyncOut", outDataBlock, 128'(0));
    chk("asyncBusy", 128'(outBusy), 128'(0));
    chk("asyncValid", 128'(outValid), 128'(0));
    @(negedge inClk);
    inRst = 1'b0;

    // Random blocks, one of them with a stray start mid-flight.
    for (int i = 0; i < 3; i++) runOne(rnd128(), rnd128(), -1);
    runOne(rnd128(), rnd128(), 5);
    runOne(rnd128(), '0, 1);

    // Back-to-back with inStart held high; data changes right after each accept.
    @(negedge inClk);
    inStart = 1'b1; inDataBlock = rnd128(); inKey = rnd128();
    q.push_back(refCt(inDataBlock, inKey));
    @(negedge inClk);
    inDataBlock = rnd128(); inKey = rnd128();
    q.push_back(refCt(inDataBlock, inKey));
    cyc = 0; last = -1; nres = 0; changePending = 1'b0;
    while (nres < 4 && cyc < 200) begin
      @(negedge inClk);
      cyc++;
      if (outValid) begin
        chk("b2bCt", outDataBlock, q.pop_front());
        if (last >= 0) chk("b2bPeriod", 128'(cyc - last), 128'(18));
        last = cyc;
        nres++;
        changePending = 1'b1;
      end else if (changePending) begin
        inDataBlock = rnd128(); inKey = rnd128();
        q.push_back(refCt(inDataBlock, inKey));
        changePending = 1'b0;
      end
    end
    chk("b2bResults", 128'(nres), 128'(4));
    inStart = 1'b0;
    repeat (22) @(negedge inClk);

    // Abort at RUN cycle 8, then rerun the known answer.
    @(negedge inClk);
    inStart = 1'b1; inDataBlock = '0; inKey = '0;
    @(negedge inClk);
    inStart = 1'b0;
    repeat (8) @(negedge inClk);
    inRst = 1'b1;
    @(negedge inClk);
    inRst = 1'b0;
    vCnt = 0; bCnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge inClk);
      if (outValid) vCnt++;
      if (outBusy)  bCnt++;
    end
    chk("abortValid", 128'(vCnt), 128'(0));
    chk("abortBusy", 128'(bCnt), 128'(0));
    chk("abortOut", outDataBlock, 128'(0));
    runOne('0, '0, -1);
    chk("abortKat", outDataBlock, KAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
